// File: rtl/daccess_arbiter_if.sv
// Bundle of the two requester ports and the shared data-access bus seen by daccess_arbiter.
// slave = arbiter side, master = requesters plus bus responder.
interface daccess_arbiter_if;
   logic        m0_req;
   logic [3:0]  m0_ren;
   logic [3:0]  m0_wen;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_gnt;
   logic        m0_rvalid;
   logic [31:0] m0_rdata;
   logic        m0_wresp;
   logic        m0_err;

   logic        m1_req;
   logic [3:0]  m1_ren;
   logic [3:0]  m1_wen;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_gnt;
   logic        m1_rvalid;
   logic [31:0] m1_rdata;
   logic        m1_wresp;
   logic        m1_err;

   logic [3:0]  daccess_ren;
   logic [3:0]  daccess_wen;
   logic [31:0] daccess_addr;
   logic [31:0] daccess_wdata;
   logic        daccess_valid;
   logic [31:0] daccess_rdata;
   logic        daccess_wresp;

   logic        busy;

   modport slave (
      input  m0_req, m0_ren, m0_wen, m0_addr, m0_wdata,
      output m0_gnt, m0_rvalid, m0_rdata, m0_wresp, m0_err,
      input  m1_req, m1_ren, m1_wen, m1_addr, m1_wdata,
      output m1_gnt, m1_rvalid, m1_rdata, m1_wresp, m1_err,
      output daccess_ren, daccess_wen, daccess_addr, daccess_wdata,
      input  daccess_valid, daccess_rdata, daccess_wresp,
      output busy
   );

   modport master (
      output m0_req, m0_ren, m0_wen, m0_addr, m0_wdata,
      input  m0_gnt, m0_rvalid, m0_rdata, m0_wresp, m0_err,
      output m1_req, m1_ren, m1_wen, m1_addr, m1_wdata,
      input  m1_gnt, m1_rvalid, m1_rdata, m1_wresp, m1_err,
      input  daccess_ren, daccess_wen, daccess_addr, daccess_wdata,
      output daccess_valid, daccess_rdata, daccess_wresp,
      input  busy
   );
endinterface

// File: rtl/daccess_arbiter.sv
// Two-port round-robin arbiter for the single-outstanding data-access bus.
// Optional WAIT timeout with forced completion: define DACCESS_TIMEOUT_EN.
module daccess_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic               cpu_clk,
   input  logic               cpu_rstn,
   daccess_arbiter_if.slave   io_bus
);

   localparam int unsigned   DW        = 32;
   localparam logic [DW-1:0] TMO_RDATA = 32'hDEAD_BEEF;

   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("daccess_arbiter: TIMEOUT_CYCLES out of range 1..65535");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t          r_state;
   logic            r_last;
   logic            r_owner;
   logic [3:0]      r_ren;
   logic [3:0]      r_wen;
   logic [DW-1:0]   r_addr;
   logic [DW-1:0]   r_wdata;
   logic            r_gnt0;
   logic            r_gnt1;
   logic [3:0]      r_bus_ren;
   logic [3:0]      r_bus_wen;
   logic            r_busy;

   logic            w_any_req;
   logic            w_pick1;
   logic [3:0]      w_sel_ren;
   logic [3:0]      w_sel_wen;
   logic [DW-1:0]   w_sel_addr;
   logic [DW-1:0]   w_sel_wdata;
   logic [3:0]      w_dec_ren;
   logic            w_wait;
   logic            w_is_wr;
   logic            w_rd_ok;
   logic            w_wr_ok;
   logic            w_tmo;
   logic            w_done;
   logic            w_rvalid;
   logic            w_wresp;
   logic [DW-1:0]   w_rdata;

   // Arbitration: a lone requester wins; on a tie the port not served last wins.
   always_comb begin
      w_any_req   = io_bus.m0_req | io_bus.m1_req;
      w_pick1     = io_bus.m1_req & (~io_bus.m0_req | ~r_last);
      w_sel_ren   = w_pick1 ? io_bus.m1_ren   : io_bus.m0_ren;
      w_sel_wen   = w_pick1 ? io_bus.m1_wen   : io_bus.m0_wen;
      w_sel_addr  = w_pick1 ? io_bus.m1_addr  : io_bus.m0_addr;
      w_sel_wdata = w_pick1 ? io_bus.m1_wdata : io_bus.m0_wdata;
      w_dec_ren   = (|w_sel_wen) ? 4'h0 : w_sel_ren;
   end

`ifdef DACCESS_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] r_tmo_cnt;

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         r_tmo_cnt <= 16'd0;
      end else if (r_state == S_ISSUE) begin
         r_tmo_cnt <= 16'd0;
      end else if (r_state == S_WAIT) begin
         r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
   end
`endif

   // Completion decode; only the response type matching the latched access counts.
   always_comb begin
      w_wait  = (r_state == S_WAIT);
      w_is_wr = |r_wen;
      w_rd_ok = w_wait & ~w_is_wr & io_bus.daccess_valid;
      w_wr_ok = w_wait &  w_is_wr & io_bus.daccess_wresp;
`ifdef DACCESS_TIMEOUT_EN
      w_tmo   = w_wait & ~(w_rd_ok | w_wr_ok) & (r_tmo_cnt == TMO_LAST);
`else
      w_tmo   = 1'b0;
`endif
      w_done   = w_rd_ok | w_wr_ok | w_tmo;
      w_rvalid = w_rd_ok | (w_tmo & ~w_is_wr);
      w_wresp  = w_wr_ok | (w_tmo &  w_is_wr);
      w_rdata  = '0;
      if (w_rd_ok) begin
         w_rdata = io_bus.daccess_rdata;
      end else if (w_tmo & ~w_is_wr) begin
         w_rdata = TMO_RDATA;
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         r_state   <= S_IDLE;
         r_last    <= 1'b1;
         r_owner   <= 1'b0;
         r_ren     <= 4'h0;
         r_wen     <= 4'h0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_bus_ren <= 4'h0;
         r_bus_wen <= 4'h0;
         r_busy    <= 1'b0;
      end else begin
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_bus_ren <= 4'h0;
         r_bus_wen <= 4'h0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_owner   <= w_pick1;
                  r_last    <= w_pick1;
                  r_ren     <= w_dec_ren;
                  r_wen     <= w_sel_wen;
                  r_addr    <= w_sel_addr;
                  r_wdata   <= w_sel_wdata;
                  r_gnt0    <= ~w_pick1;
                  r_gnt1    <= w_pick1;
                  r_bus_ren <= w_dec_ren;
                  r_bus_wen <= w_sel_wen;
                  r_busy    <= 1'b1;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // A null access is granted but never gets a bus response.
               if (r_ren == 4'h0 && r_wen == 4'h0) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_done) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign io_bus.m0_gnt    = r_gnt0;
   assign io_bus.m0_rvalid = w_rvalid & ~r_owner;
   assign io_bus.m0_rdata  = r_owner ? '0 : w_rdata;
   assign io_bus.m0_wresp  = w_wresp & ~r_owner;
   assign io_bus.m0_err    = w_tmo & ~r_owner;

   assign io_bus.m1_gnt    = r_gnt1;
   assign io_bus.m1_rvalid = w_rvalid & r_owner;
   assign io_bus.m1_rdata  = r_owner ? w_rdata : '0;
   assign io_bus.m1_wresp  = w_wresp & r_owner;
   assign io_bus.m1_err    = w_tmo & r_owner;

   assign io_bus.daccess_ren   = r_bus_ren;
   assign io_bus.daccess_wen   = r_bus_wen;
   assign io_bus.daccess_addr  = r_addr;
   assign io_bus.daccess_wdata = r_wdata;
   assign io_bus.busy          = r_busy;

endmodule

// File: tb/tb_daccess_arbiter.sv
// Directed self-checking bench for daccess_arbiter (timeout section follows DACCESS_TIMEOUT_EN).
module tb_daccess_arbiter;

   logic cpu_clk  = 1'b0;
   logic cpu_rstn = 1'b0;
   int   n_chk    = 0;
   int   n_pass   = 0;

   daccess_arbiter_if bus_if ();

   daccess_arbiter #(.TIMEOUT_CYCLES(8)) u_dut (
      .cpu_clk  (cpu_clk),
      .cpu_rstn (cpu_rstn),
      .io_bus   (bus_if.slave)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic drive_m0(input logic req, input logic [3:0] ren, input logic [3:0] wen,
                           input logic [31:0] addr, input logic [31:0] wdata);
      bus_if.m0_req = req; bus_if.m0_ren = ren; bus_if.m0_wen = wen;
      bus_if.m0_addr = addr; bus_if.m0_wdata = wdata;
   endtask

   task automatic drive_m1(input logic req, input logic [3:0] ren, input logic [3:0] wen,
                           input logic [31:0] addr, input logic [31:0] wdata);
      bus_if.m1_req = req; bus_if.m1_ren = ren; bus_if.m1_wen = wen;
      bus_if.m1_addr = addr; bus_if.m1_wdata = wdata;
   endtask

   task automatic bus_resp(input logic valid, input logic wresp, input logic [31:0] rdata);
      bus_if.daccess_valid = valid; bus_if.daccess_wresp = wresp; bus_if.daccess_rdata = rdata;
      #1;
   endtask

   task automatic do_reset();
      cpu_rstn = 1'b0;
      tick();
      cpu_rstn = 1'b1;
      tick();
   endtask

   initial begin
      drive_m0(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
      drive_m1(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
      bus_resp(1'b0, 1'b0, 32'h0);
      repeat (3) tick();

      // reset values
      chk("rst_busy", 32'(bus_if.busy), 32'd0);
      chk("rst_m0_gnt", 32'(bus_if.m0_gnt), 32'd0);
      chk("rst_bus_ren", 32'(bus_if.daccess_ren), 32'd0);
      chk("rst_bus_addr", bus_if.daccess_addr, 32'd0);
      chk("rst_m1_rvalid", 32'(bus_if.m1_rvalid), 32'd0);
      cpu_rstn = 1'b1;
      tick();

      // single read, response three cycles after the bus pulse
      drive_m0(1'b1, 4'hF, 4'h0, 32'h1C00_0010, 32'h0);
      tick();
      chk("rd_gnt", 32'(bus_if.m0_gnt), 32'd1);
      chk("rd_m1_gnt", 32'(bus_if.m1_gnt), 32'd0);
      chk("rd_bus_ren", 32'(bus_if.daccess_ren), 32'hF);
      chk("rd_bus_addr", bus_if.daccess_addr, 32'h1C00_0010);
      chk("rd_busy", 32'(bus_if.busy), 32'd1);
      drive_m0(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
      tick();
      chk("rd_gnt_pulse", 32'(bus_if.m0_gnt), 32'd0);
      chk("rd_wait_ren", 32'(bus_if.daccess_ren), 32'd0);
      tick();
      tick();
      bus_resp(1'b1, 1'b0, 32'h1234_5678);
      chk("rd_rvalid", 32'(bus_if.m0_rvalid), 32'd1);
      chk("rd_rdata", bus_if.m0_rdata, 32'h1234_5678);
      chk("rd_m1_rvalid", 32'(bus_if.m1_rvalid), 32'd0);
      tick();
      bus_resp(1'b0, 1'b0, 32'h0);
      chk("rd_busy_drop", 32'(bus_if.busy), 32'd0);
      chk("rd_rvalid_drop", 32'(bus_if.m0_rvalid), 32'd0);
      chk("rd_rdata_zero", bus_if.m0_rdata, 32'd0);

      // tie round-robin from reset
      do_reset();
      drive_m0(1'b1, 4'h0, 4'hF, 32'h0000_0100, 32'h1111_1111);
      drive_m1(1'b1, 4'h0, 4'hC, 32'h0000_0200, 32'h2222_2222);
      tick();
      chk("tie1_m0_gnt", 32'(bus_if.m0_gnt), 32'd1);
      chk("tie1_m1_gnt", 32'(bus_if.m1_gnt), 32'd0);
      chk("tie1_wen", 32'(bus_if.daccess_wen), 32'hF);
      chk("tie1_addr", bus_if.daccess_addr, 32'h0000_0100);
      bus_if.m0_req = 1'b0;
      tick();
      bus_resp(1'b0, 1'b1, 32'h0);
      chk("tie1_m0_wresp", 32'(bus_if.m0_wresp), 32'd1);
      chk("tie1_m1_wresp", 32'(bus_if.m1_wresp), 32'd0);
      tick();
      bus_resp(1'b0, 1'b0, 32'h0);
      bus_if.m0_req = 1'b1;
      tick();
      chk("tie2_m1_gnt", 32'(bus_if.m1_gnt), 32'd1);
      chk("tie2_m0_gnt", 32'(bus_if.m0_gnt), 32'd0);
      chk("tie2_wen", 32'(bus_if.daccess_wen), 32'hC);
      chk("tie2_wdata", bus_if.daccess_wdata, 32'h2222_2222);
      bus_if.m1_req = 1'b0;
      tick();
      bus_resp(1'b0, 1'b1, 32'h0);
      chk("tie2_m1_wresp", 32'(bus_if.m1_wresp), 32'd1);
      chk("tie2_m0_wresp", 32'(bus_if.m0_wresp), 32'd0);
      tick();
      bus_resp(1'b0, 1'b0, 32'h0);
      bus_if.m1_req = 1'b1;
      tick();
      chk("tie3_m0_gnt", 32'(bus_if.m0_gnt), 32'd1);
      chk("tie3_m1_gnt", 32'(bus_if.m1_gnt), 32'd0);
      bus_if.m0_req = 1'b0;
      tick();
      bus_resp(1'b0, 1'b1, 32'h0);
      tick();
      bus_resp(1'b0, 1'b0, 32'h0);
      tick();
      chk("tie4_m1_gnt", 32'(bus_if.m1_gnt), 32'd1);
      bus_if.m1_req = 1'b0;
      tick();
      bus_resp(1'b0, 1'b1, 32'h0);
      chk("tie4_m1_wresp", 32'(bus_if.m1_wresp), 32'd1);
      tick();
      bus_resp(1'b0, 1'b0, 32'h0);

      // spurious valid in IDLE, then write with spurious valid in WAIT
      bus_resp(1'b1, 1'b0, 32'h5A5A_5A5A);
      chk("idle_spur_m0", 32'(bus_if.m0_rvalid), 32'd0);
      chk("idle_spur_m1", 32'(bus_if.m1_rvalid), 32'd0);
      bus_resp(1'b0, 1'b0, 32'h0);
      drive_m1(1'b1, 4'h0, 4'h3, 32'h0000_0300, 32'hAAAA_5555);
      tick();
      chk("ws_gnt", 32'(bus_if.m1_gnt), 32'd1);
      chk("ws_wen", 32'(bus_if.daccess_wen), 32'h3);
      chk("ws_wdata", bus_if.daccess_wdata, 32'hAAAA_5555);
      drive_m1(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
      tick();
      bus_resp(1'b1, 1'b0, 32'hFFFF_FFFF);
      chk("ws_spur_rvalid", 32'(bus_if.m1_rvalid), 32'd0);
      chk("ws_spur_wresp", 32'(bus_if.m1_wresp), 32'd0);
      chk("ws_spur_rdata", bus_if.m1_rdata, 32'd0);
      tick();
      bus_resp(1'b0, 1'b0, 32'h0);
      chk("ws_still_busy", 32'(bus_if.busy), 32'd1);
      chk("ws_wait_wen", 32'(bus_if.daccess_wen), 32'd0);
      chk("ws_wdata_hold", bus_if.daccess_wdata, 32'hAAAA_5555);
      bus_resp(1'b0, 1'b1, 32'h0);
      chk("ws_wresp", 32'(bus_if.m1_wresp), 32'd1);
      tick();
      bus_resp(1'b0, 1'b0, 32'h0);
      chk("ws_idle", 32'(bus_if.busy), 32'd0);

      // null request: granted, no bus pulse, no response
      drive_m0(1'b1, 4'h0, 4'h0, 32'h0000_0400, 32'h0);
      tick();
      chk("nl_gnt", 32'(bus_if.m0_gnt), 32'd1);
      chk("nl_ren", 32'(bus_if.daccess_ren), 32'd0);
      chk("nl_wen", 32'(bus_if.daccess_wen), 32'd0);
      chk("nl_busy", 32'(bus_if.busy), 32'd1);
      drive_m0(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
      tick();
      chk("nl_idle", 32'(bus_if.busy), 32'd0);
      bus_resp(1'b1, 1'b1, 32'h7777_7777);
      chk("nl_no_rvalid", 32'(bus_if.m0_rvalid), 32'd0);
      chk("nl_no_wresp", 32'(bus_if.m0_wresp), 32'd0);
      bus_resp(1'b0, 1'b0, 32'h0);

      // illegal ren+wen: treated as a write
      drive_m1(1'b1, 4'hF, 4'hF, 32'h0000_0500, 32'h0000_0005);
      tick();
      chk("il_gnt", 32'(bus_if.m1_gnt), 32'd1);
      chk("il_wen", 32'(bus_if.daccess_wen), 32'hF);
      chk("il_ren", 32'(bus_if.daccess_ren), 32'd0);
      drive_m1(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
      tick();
      bus_resp(1'b1, 1'b0, 32'h1);
      chk("il_no_rvalid", 32'(bus_if.m1_rvalid), 32'd0);
      bus_resp(1'b0, 1'b1, 32'h0);
      chk("il_wresp", 32'(bus_if.m1_wresp), 32'd1);
      tick();
      bus_resp(1'b0, 1'b0, 32'h0);

      // reset during WAIT discards the pending response
      drive_m0(1'b1, 4'hF, 4'h0, 32'h0000_0600, 32'h0);
      tick();
      chk("rs_gnt", 32'(bus_if.m0_gnt), 32'd1);
      drive_m0(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
      tick();
      chk("rs_wait_busy", 32'(bus_if.busy), 32'd1);
      cpu_rstn = 1'b0;
      #1;
      chk("rs_busy", 32'(bus_if.busy), 32'd0);
      chk("rs_addr", bus_if.daccess_addr, 32'd0);
      chk("rs_rvalid", 32'(bus_if.m0_rvalid), 32'd0);
      tick();
      cpu_rstn = 1'b1;
      tick();
      bus_resp(1'b1, 1'b0, 32'hCAFE_F00D);
      chk("rs_no_rvalid", 32'(bus_if.m0_rvalid), 32'd0);
      chk("rs_no_rdata", bus_if.m0_rdata, 32'd0);
      chk("rs_idle", 32'(bus_if.busy), 32'd0);
      tick();
      bus_resp(1'b0, 1'b0, 32'h0);

      // read with no response
      drive_m0(1'b1, 4'hF, 4'h0, 32'h0000_0700, 32'h0);
      tick();
      drive_m0(1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
      tick();
`ifdef DACCESS_TIMEOUT_EN
      repeat (6) tick();
      chk("to_early_rvalid", 32'(bus_if.m0_rvalid), 32'd0);
      chk("to_early_err", 32'(bus_if.m0_err), 32'd0);
      tick();
      chk("to_rvalid", 32'(bus_if.m0_rvalid), 32'd1);
      chk("to_err", 32'(bus_if.m0_err), 32'd1);
      chk("to_rdata", bus_if.m0_rdata, 32'hDEAD_BEEF);
      chk("to_m1_err", 32'(bus_if.m1_err), 32'd0);
      tick();
      chk("to_idle", 32'(bus_if.busy), 32'd0);
      bus_resp(1'b1, 1'b0, 32'h0BAD_0BAD);
      chk("to_late", 32'(bus_if.m0_rvalid), 32'd0);
      bus_resp(1'b0, 1'b0, 32'h0);
`else
      repeat (20) tick();
      chk("nt_busy", 32'(bus_if.busy), 32'd1);
      chk("nt_err", 32'(bus_if.m0_err), 32'd0);
      chk("nt_rvalid", 32'(bus_if.m0_rvalid), 32'd0);
      bus_resp(1'b1, 1'b0, 32'h0BAD_0BAD);
      chk("nt_rvalid_late", 32'(bus_if.m0_rvalid), 32'd1);
      chk("nt_err_late", 32'(bus_if.m0_err), 32'd0);
      tick();
      bus_resp(1'b0, 1'b0, 32'h0);
      chk("nt_idle", 32'(bus_if.busy), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
